// File: rtl/micro_sequencer.sv
// micro_sequencer: reads the microcode control store, issues the datapath
// control field and computes the next microaddress (NEXT / JAM / DISPATCH).
//
// state  | meaning
// S_RUN  | executing the microword at MPC each cycle mem_busy is low
// S_WAIT | memory stall, MPC and flags frozen, word re-executed on return
// S_HALT | stopped (address 127 reached or illegal opcode), reset to leave
module micro_sequencer #(
  parameter int AW    = 7,
  parameter int DW    = 23,
  parameter int FETCH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic [7:0]    opcode,
  input  logic          z_in,
  input  logic          n_in,
  input  logic          mem_busy,
  output logic [11:0]   ctrl,
  output logic          ctrl_valid,
  output logic          halted,
  output logic          illegal_op
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [AW-1:0] FETCH_ADDR = AW'(FETCH);
  localparam logic [AW-1:0] HALT_ADDR  = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] mpc_q, mpc_d;
  logic          z_q, z_d;
  logic          n_q, n_d;
  logic          halted_q, halted_d;
  logic          illegal_q, illegal_d;

  logic [AW-1:0] entry_addr;
  logic          entry_ok;
  logic          is_dispatch;
  logic          jam_taken;
  logic [AW-1:0] seq_addr;

  assign rom_addr   = mpc_q;
  assign ctrl       = rom_data[22:11];
  assign ctrl_valid = rst_n && (state_q == S_RUN) && !mem_busy;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;

  // Opcode dispatch table: entry address of each microroutine.
  always_comb begin
    entry_ok   = 1'b1;
    entry_addr = '0;
    case (opcode)
      8'h00: entry_addr = AW'(1);
      8'h10: entry_addr = AW'(2);
      8'hA7: entry_addr = AW'(4);
      8'h60: entry_addr = AW'(5);
      8'h99: entry_addr = AW'(9);
      8'h9B: entry_addr = AW'(14);
      8'h9F: entry_addr = AW'(19);
      8'h84: entry_addr = AW'(27);
      8'h15: entry_addr = AW'(34);
      8'h36: entry_addr = AW'(38);
      8'h64: entry_addr = AW'(43);
      8'h59: entry_addr = AW'(47);
      8'h7E: entry_addr = AW'(49);
      8'h5F: entry_addr = AW'(53);
      8'hC4: entry_addr = AW'(58);
      8'h80: entry_addr = AW'(59);
      8'h13: entry_addr = AW'(63);
      8'h57: entry_addr = AW'(66);
      8'hB6: entry_addr = AW'(71);
      8'hAC: entry_addr = AW'(87);
      default: entry_ok = 1'b0;
    endcase
  end

  // Next-state, next-MPC and flag computation.
  always_comb begin
    state_d     = state_q;
    mpc_d       = mpc_q;
    z_d         = z_q;
    n_d         = n_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    is_dispatch = (rom_data[8:7] == 2'b11);
    jam_taken   = (rom_data[10] & z_q) | (rom_data[9] & n_q);
    seq_addr    = jam_taken ? (mpc_q + AW'(1)) : rom_data[AW-1:0];
    case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          state_d = S_WAIT;
        end else begin
          z_d = z_in;
          n_d = n_in;
          if (is_dispatch) begin
            if (entry_ok) begin
              mpc_d = entry_addr;
            end else begin
              illegal_d = 1'b1;
              halted_d  = 1'b1;
              state_d   = S_HALT;
            end
          end else if (seq_addr == HALT_ADDR) begin
            mpc_d    = HALT_ADDR;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            mpc_d = seq_addr;
          end
        end
      end
      S_WAIT: begin
        if (!mem_busy) state_d = S_RUN;
      end
      default: begin
        halted_d = 1'b1;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      mpc_q     <= FETCH_ADDR;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mpc_q     <= mpc_d;
      z_q       <= z_d;
      n_q       <= n_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: directed microwords, expected issued
// (address, ctrl) pairs queued by the stimulus and checked by a monitor.
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic [6:0]  rom_addr;
  logic [22:0] rom_data;
  logic [7:0]  opcode;
  logic        z_in;
  logic        n_in;
  logic        mem_busy;
  logic [11:0] ctrl;
  logic        ctrl_valid;
  logic        halted;
  logic        illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [6:0]  addr;
    logic [11:0] ctrl;
  } issue_t;

  issue_t exp_q[$];

  micro_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .opcode     (opcode),
    .z_in       (z_in),
    .n_in       (n_in),
    .mem_busy   (mem_busy),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [22:0] mw(input logic [11:0] c, input logic jz,
                                     input logic jn, input logic [1:0] br,
                                     input logic [6:0] nx);
    return {c, jz, jn, br, nx};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every issued microword must match the oldest queued expectation.
  initial begin
    issue_t e;
    forever begin
      @(negedge clk);
      if (ctrl_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue_unexpected: addr %0d ctrl %h issued, none expected",
                   rom_addr, ctrl);
        end else begin
          e = exp_q.pop_front();
          if (rom_addr !== e.addr || ctrl !== e.ctrl) begin
            n_fail++;
            $display("FAIL issue: got addr %0d ctrl %h expected addr %0d ctrl %h",
                     rom_addr, ctrl, e.addr, e.ctrl);
          end
        end
      end
    end
  end

  // One cycle: present word/inputs, check MPC and issue flag, queue expectation.
  task automatic step(input int exp_addr, input logic [22:0] w, input logic [7:0] op,
                      input logic z, input logic n, input logic busy, input logic exp_v);
    rom_data = w;
    opcode   = op;
    z_in     = z;
    n_in     = n;
    mem_busy = busy;
    #2;
    chk("rom_addr", int'(rom_addr), exp_addr);
    chk("ctrl_valid", int'(ctrl_valid), int'(exp_v));
    if (exp_v) exp_q.push_back('{addr: 7'(exp_addr), ctrl: w[22:11]});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("ctrl_valid_in_reset", int'(ctrl_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("halted_after_reset", int'(halted), 0);
    chk("illegal_after_reset", int'(illegal_op), 0);
  endtask

  logic [7:0] ops [20] = '{8'h00, 8'h10, 8'hA7, 8'h60, 8'h99, 8'h9B, 8'h9F,
                           8'h84, 8'h15, 8'h36, 8'h64, 8'h59, 8'h7E, 8'h5F,
                           8'hC4, 8'h80, 8'h13, 8'h57, 8'hB6, 8'hAC};
  int         ents [20] = '{1, 2, 4, 5, 9, 14, 19, 27, 34, 38, 43, 47, 49, 53,
                            58, 59, 63, 66, 71, 87};

  initial begin
    rst_n    = 1'b0;
    rom_data = '0;
    opcode   = '0;
    z_in     = 1'b0;
    n_in     = 1'b0;
    mem_busy = 1'b0;
    #1;
    do_reset();

    // NEXT, dispatch, JAMZ taken / not taken
    step(0,  mw(12'hA01, 0, 0, 2'b00, 7'd91), 8'h00, 0, 0, 0, 1);
    step(91, mw(12'hB02, 0, 0, 2'b11, 7'd0),  8'h60, 0, 0, 0, 1);
    step(5,  mw(12'hC03, 0, 0, 2'b00, 7'd10), 8'h00, 1, 0, 0, 1);
    step(10, mw(12'hD04, 1, 0, 2'b00, 7'd12), 8'h00, 0, 0, 0, 1);
    step(11, mw(12'hD05, 1, 0, 2'b00, 7'd12), 8'h00, 0, 0, 0, 1);
    step(12, mw(12'hE06, 0, 0, 2'b00, 7'd35), 8'h00, 1, 0, 0, 1);

    // memory stall at 35: flags must survive the stall (Z=1 -> jam to 36)
    for (int i = 0; i < 3; i++)
      step(35, mw(12'hF07, 1, 0, 2'b00, 7'd40), 8'h00, 0, 1, 1, 0);
    step(35, mw(12'hF07, 1, 0, 2'b00, 7'd40), 8'h00, 0, 1, 0, 0);
    step(35, mw(12'hF07, 1, 0, 2'b00, 7'd40), 8'h00, 0, 0, 0, 1);

    // illegal opcode halts, sticky until reset
    step(36, mw(12'h123, 0, 0, 2'b11, 7'd0), 8'hFF, 0, 0, 0, 1);
    step(36, mw(12'h124, 0, 0, 2'b11, 7'd0), 8'h60, 0, 0, 0, 0);
    chk("halted_illegal", int'(halted), 1);
    chk("illegal_op", int'(illegal_op), 1);
    step(36, mw(12'h125, 0, 0, 2'b00, 7'd3), 8'h00, 1, 1, 0, 0);
    chk("illegal_sticky", int'(illegal_op), 1);
    do_reset();

    // MPC 126 with JAMN taken -> 127 halt
    step(0,   mw(12'h0AA, 0, 0, 2'b00, 7'd126), 8'h00, 0, 1, 0, 1);
    step(126, mw(12'h0BB, 0, 1, 2'b00, 7'd3),   8'h00, 0, 0, 0, 1);
    chk("halted_wrap", int'(halted), 1);
    step(127, mw(12'h0CC, 0, 0, 2'b00, 7'd5),   8'h00, 0, 0, 0, 0);
    chk("illegal_wrap", int'(illegal_op), 0);
    do_reset();

    // reset while in WAIT clears flags
    step(0,  mw(12'h0DD, 0, 0, 2'b00, 7'd50), 8'h00, 1, 1, 0, 1);
    step(50, mw(12'h0EE, 0, 0, 2'b00, 7'd60), 8'h00, 0, 0, 1, 0);
    do_reset();
    step(0,  mw(12'h0FF, 1, 1, 2'b00, 7'd7),  8'h00, 0, 0, 0, 1);

    // reserved branch encodings behave as plain NEXT
    step(7,  mw(12'h111, 0, 0, 2'b01, 7'd8),  8'h60, 0, 0, 0, 1);
    step(8,  mw(12'h112, 0, 0, 2'b10, 7'd0),  8'h60, 0, 0, 0, 1);

    // full dispatch table
    for (int i = 0; i < 20; i++) begin
      step(0,       mw(12'h300 + 12'(i), 0, 0, 2'b11, 7'd0), ops[i], 0, 0, 0, 1);
      step(ents[i], mw(12'h400 + 12'(i), 0, 0, 2'b00, 7'd0), 8'hFF,  0, 0, 0, 1);
    end
    chk("illegal_after_table", int'(illegal_op), 0);

    // NEXT = 127 halts directly
    step(0,   mw(12'h222, 0, 0, 2'b00, 7'd127), 8'h00, 0, 0, 0, 1);
    step(127, mw(12'h223, 0, 0, 2'b00, 7'd1),   8'h00, 0, 0, 0, 0);
    chk("halted_next127", int'(halted), 1);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
